gf_div_seq: RTL

GF_DIV_SEQ -- requirements
Module: gf_div_seq

---
 rtl/gf_div_seq.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/gf_div_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// gf_div_seq -- sequential GF(2^m) divider
//
// Computes out_q = in_a / in_b in GF(2^SYM_W) as in_a * in_b^(2^m-2) mod POLY.
// The inverse is built by square-and-multiply over the bits of 2^m-2, which
// are all ones except bit 0. So acc collects b^2 * b^4 * ... * b^(2^(m-1)).
// Latency is fixed (SYM_W+1 edges from accept to out_valid) for every
// operand, including a zero divisor.
//
// Parameters
//   SYM_W  field width m (3..8)
//   POLY   primitive polynomial, SYM_W+1 bits, MSB set
//   TAG_W  width of the sideband tag
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair present
//   in_ready   block idle and able to accept operands
//   in_a       dividend
//   in_b       divisor
//   in_tag     sideband tag, returned with the quotient
//   flush      synchronous abort; returns the block to idle
//   out_valid  quotient present
//   out_ready  consumer takes the quotient
//   out_q      quotient
//   out_dbz    divisor was zero (out_q is then 0)
//   out_tag    tag of the operation that produced out_q
// ---------------------------------------------------------------------------
module gf_div_seq #(
    parameter int               SYM_W = 4,
    parameter logic [SYM_W:0]   POLY  = 5'h13,
    parameter int               TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_a,
    input  logic [SYM_W-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_q,
    output logic             out_dbz,
    output logic [TAG_W-1:0] out_tag
);

    localparam int              CNT_W    = $clog2(SYM_W);
    // Number of multiply/square steps needed for the inverse.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYM_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INV  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Field multiply: MSB-first shift-and-reduce. Each step doubles the
    // partial product (reducing by POLY when the top bit falls off) and adds
    // the multiplicand when the current multiplier bit is set.
    // -----------------------------------------------------------------------
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] x,
                                                input logic [SYM_W-1:0] y);
        logic [SYM_W-1:0] p;
        p = '0;
        for (int i = SYM_W - 1; i >= 0; i--) begin
            if (p[SYM_W-1]) begin
                p = (p << 1) ^ POLY[SYM_W-1:0];
            end else begin
                p = p << 1;
            end
            if (y[i]) begin
                p = p ^ x;
            end
        end
        return p;
    endfunction

    // State and datapath registers
    state_t           state_q,  state_d;
    logic [SYM_W-1:0] a_q,      a_d;
    logic [SYM_W-1:0] b_q,      b_d;
    logic [TAG_W-1:0] tag_q,    tag_d;
    logic [SYM_W-1:0] sq_q,     sq_d;
    logic [SYM_W-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [SYM_W-1:0] res_q,    res_d;
    logic             dbz_q,    dbz_d;
    logic [TAG_W-1:0] otag_q,   otag_d;

    // Combinational field operations used by the FSM
    logic [SYM_W-1:0] b_sq;       // in_b^2, seeds sq on accept
    logic [SYM_W-1:0] acc_mul;    // acc * sq
    logic [SYM_W-1:0] sq_sq;      // sq^2
    logic [SYM_W-1:0] quot;       // a * acc

    assign b_sq    = gf_mul(in_b, in_b);
    assign acc_mul = gf_mul(acc_q, sq_q);
    assign sq_sq   = gf_mul(sq_q, sq_q);
    assign quot    = gf_mul(a_q, acc_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        sq_d    = sq_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dbz_d   = dbz_q;
        otag_d  = otag_q;

        if (flush) begin
            // Abort wins over both handshakes in the same cycle.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_d     = in_a;
                        b_d     = in_b;
                        tag_d   = in_tag;
                        sq_d    = b_sq;
                        acc_d   = {{(SYM_W-1){1'b0}}, 1'b1};
                        cnt_d   = '0;
                        state_d = INV;
                    end
                end
                INV: begin
                    // cnt counts completed steps; once SYM_W-1 have been
                    // applied, acc holds b^(2^m-2) and the FSM moves on.
                    // A zero divisor simply yields acc=0, so no special path
                    // is needed and latency stays constant.
                    if (cnt_q == LAST_CNT) begin
                        state_d = MUL;
                    end else begin
                        acc_d = acc_mul;
                        sq_d  = sq_sq;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MUL: begin
                    res_d   = quot;
                    dbz_d   = (b_q == '0);
                    otag_d  = tag_q;
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            sq_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
            otag_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            sq_q    <= sq_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
            otag_q  <= otag_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_q     = res_q;
    assign out_dbz   = dbz_q;
    assign out_tag   = otag_q;

endmodule
